// File: rtl/la_serializer_pkg.sv
// Shared types and line levels for the la_serializer single-wire transmitter.
package la_serializer_pkg;

  // Frame states. PARITY is only reachable in builds with parity enabled.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels for the non-data parts of a frame.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/la_serializer_tick.sv
// Bit-period timer for la_serializer: counts 0..DIV-1 and flags the last
// cycle of each serial bit period.
module la_serializer_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Period counter: restarts on clear or after its terminal value, never wraps past it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CNT_LAST);

endmodule

// File: rtl/la_serializer.sv
// Transmit end of the lambdalib single-wire serial link. Accepts a word over
// valid/ready and sends start, data, optional parity and stop bits, each held
// for DIV clock cycles. The line idles high and tx comes straight from a flop.
// Optional even parity: define LA_SERIALIZER_PARITY_EN.
module la_serializer
  import la_serializer_pkg::*;
#(
  parameter int DW       = 8,
  parameter int DIV      = 1,
  parameter int LSBFIRST = 1,
  parameter     PROP     = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          tx,
  output logic          busy
);

  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  // PROP only steers tech mapping; the generic implementation is identical for any value.
  if (PROP == "") begin : g_prop_unset
  end

  state_t        r_state;
  logic [DW-1:0] r_shift;
  logic [BW-1:0] r_bitcnt;
  logic          r_tx;
`ifdef LA_SERIALIZER_PARITY_EN
  logic          r_parity;
`endif

  logic          w_tick;
  logic          w_xfer;
  logic          w_clear;
  logic [DW-1:0] w_shift_next;
  logic          w_first_bit;
  logic          w_next_bit;

  // A new word is taken while idle, or in the final STOP cycle for gapless frames.
  assign in_ready = !reset && ((r_state == IDLE) || ((r_state == STOP) && w_tick));
  assign w_xfer   = in_valid && in_ready;

  // Hold the period timer at zero while idle and restart it on every accepted word.
  assign w_clear  = (r_state == IDLE) || w_xfer;

  // The outgoing bit always sits at the end of the register nearest the line.
  assign w_shift_next = (LSBFIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
  assign w_first_bit  = (LSBFIRST != 0) ? r_shift[0]      : r_shift[DW-1];
  assign w_next_bit   = (LSBFIRST != 0) ? w_shift_next[0] : w_shift_next[DW-1];

  la_serializer_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Frame sequencer: state, shift register, bit counter and the registered line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_tx     <= LINE_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
`ifdef LA_SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_state  <= START;
      r_tx     <= LINE_START;
      r_shift  <= in_data;
      r_bitcnt <= '0;
`ifdef LA_SERIALIZER_PARITY_EN
      r_parity <= ^in_data;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= LINE_IDLE;
        end
        START: begin
          if (w_tick) begin
            r_state <= DATA;
            r_tx    <= w_first_bit;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bitcnt == BIT_LAST) begin
`ifdef LA_SERIALIZER_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= LINE_STOP;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
              r_shift  <= w_shift_next;
              r_tx     <= w_next_bit;
            end
          end
        end
`ifdef LA_SERIALIZER_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= LINE_STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state <= IDLE;
            r_tx    <= LINE_IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_la_serializer.sv
// Self-checking bench for la_serializer: one instance at DIV=1/LSB-first and
// one at DIV=4/MSB-first, both DW=8. Builds with or without LA_SERIALIZER_PARITY_EN.
module tb_la_serializer;

  typedef struct {
    logic [7:0] data;   // word presented on in_data
    logic [7:0] order;  // data bits in transmit order, first-sent bit at [7]
    logic       par;    // even parity of data
    bit         poke;   // pulse in_valid while the frame is in flight
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, a_ready, a_tx, a_busy;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_tx, b_busy;
  logic [7:0] b_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  la_serializer #(.DW(8), .DIV(1), .LSBFIRST(1), .PROP("DEFAULT")) dut_a (
    .clk (clk), .reset (reset), .in_valid (a_valid), .in_data (a_data),
    .in_ready (a_ready), .tx (a_tx), .busy (a_busy)
  );

  la_serializer #(.DW(8), .DIV(4), .LSBFIRST(0), .PROP("DEFAULT")) dut_b (
    .clk (clk), .reset (reset), .in_valid (b_valid), .in_data (b_data),
    .in_ready (b_ready), .tx (b_tx), .busy (b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (a_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_wait", a_ready, 1);
  endtask

  // Returns at the negedge right after the accepting edge (start-bit sample).
  task automatic send_a(input logic [7:0] d);
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = d;
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = 8'h00;
  endtask

  // Called at the start-bit sample; ends at the stop sample, or one idle sample later if last.
  task automatic expect_frame_a(input string tag, input logic [7:0] order, input logic par,
                                input bit poke, input bit last);
    check({tag, "_start"}, {a_tx, a_busy}, 2'b01);
    if (poke) begin
      check({tag, "_ready_start"}, a_ready, 0);
      a_valid = 1'b1;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("%s_bit%0d", tag, i), {a_tx, a_busy}, {order[7-i], 1'b1});
      if (poke) begin
        check($sformatf("%s_ready_bit%0d", tag, i), a_ready, 0);
        a_valid = (i < 7);
      end
    end
`ifdef LA_SERIALIZER_PARITY_EN
    @(negedge clk);
    check({tag, "_parity"}, {a_tx, a_busy}, {par, 1'b1});
`else
    if (par === 1'bx) check({tag, "_par_known"}, par, 0);
`endif
    @(negedge clk);
    check({tag, "_stop"}, {a_tx, a_busy, a_ready}, 3'b111);
    if (last) begin
      @(negedge clk);
      check({tag, "_idle"}, {a_tx, a_busy, a_ready}, 3'b101);
    end
  endtask

  // Called at the start-bit sample of dut_b; checks every cycle of the frame.
  task automatic expect_frame_b(input logic [7:0] d, input logic par);
    bit bits[$];
    int cyc = 0;
    bits.push_back(1'b0);
    for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
`ifdef LA_SERIALIZER_PARITY_EN
    bits.push_back(par);
`else
    if (par === 1'bx) check("b_par_known", par, 0);
`endif
    bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < 4; c++) begin
        if (cyc != 0) @(negedge clk);
        check($sformatf("b_%0h_bit%0d_cyc%0d", d, k, c), {b_tx, b_busy}, {bits[k], 1'b1});
        cyc++;
      end
    end
    @(negedge clk);
    check($sformatf("b_%0h_idle", d), {b_tx, b_busy, b_ready}, 3'b101);
  endtask

  vec_t vecs[6];
  vec_t bvecs[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, order: 8'hA5, par: 1'b0, poke: 1'b0};
    vecs[1] = '{data: 8'h01, order: 8'h80, par: 1'b1, poke: 1'b0};
    vecs[2] = '{data: 8'hFF, order: 8'hFF, par: 1'b0, poke: 1'b0};
    vecs[3] = '{data: 8'h07, order: 8'hE0, par: 1'b1, poke: 1'b0};
    vecs[4] = '{data: 8'h3C, order: 8'h3C, par: 1'b0, poke: 1'b1};
    vecs[5] = '{data: 8'h12, order: 8'h48, par: 1'b0, poke: 1'b1};
    bvecs[0] = '{data: 8'h80, order: 8'h80, par: 1'b1, poke: 1'b0};
    bvecs[1] = '{data: 8'hC3, order: 8'hC3, par: 1'b0, poke: 1'b0};

    reset   = 1'b1;
    a_valid = 1'b0;
    a_data  = 8'h00;
    b_valid = 1'b0;
    b_data  = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_a", {a_tx, a_busy, a_ready}, 3'b100);
    check("reset_b", {b_tx, b_busy, b_ready}, 3'b100);
    reset = 1'b0;
    #1;
    check("ready_after_reset_a", a_ready, 1);
    check("ready_after_reset_b", b_ready, 1);

    // Single frames on the DIV=1, LSB-first instance; some with in_valid pulsed mid-frame.
    for (int v = 0; v < 6; v++) begin
      send_a(vecs[v].data);
      expect_frame_a($sformatf("a_%0h", vecs[v].data), vecs[v].order, vecs[v].par,
                     vecs[v].poke, 1'b1);
    end

    // Back-to-back: in_valid held, second word taken in the last STOP cycle.
    wait_ready_a();
    a_valid = 1'b1;
    a_data  = 8'h01;
    @(negedge clk);
    a_data  = 8'hFF;
    expect_frame_a("b2b_first", 8'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = 8'h00;
    expect_frame_a("b2b_second", 8'hFF, 1'b0, 1'b0, 1'b1);

    // DIV=4, MSB-first frames.
    for (int v = 0; v < 2; v++) begin
      begin : b_send
        int n = 0;
        while (b_ready !== 1'b1 && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("b_ready_wait", b_ready, 1);
      end
      b_valid = 1'b1;
      b_data  = bvecs[v].data;
      @(negedge clk);
      b_valid = 1'b0;
      b_data  = 8'h00;
      expect_frame_b(bvecs[v].order, bvecs[v].par);
    end

    // Reset in the middle of DATA aborts the frame.
    send_a(8'h00);
    repeat (3) @(negedge clk);
    check("mid_data_tx_low", {a_tx, a_busy}, 2'b01);
    reset = 1'b1;
    #1;
    check("rst_ready_low", a_ready, 0);
    @(negedge clk);
    check("rst_abort", {a_tx, a_busy, a_ready}, 3'b100);
    reset = 1'b0;
    #1;
    check("rst_ready_after", a_ready, 1);
    send_a(8'h12);
    expect_frame_a("post_rst", 8'h48, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
